// File: rtl/hls_deadlock_multi_monitor.sv
// Deadlock/stall monitor for an HLS dataflow region: persistence-filtered alarm over
// AXIS block and sub-instance idle/block signals, with first-blocker capture and stall counter.
module hls_deadlock_multi_monitor #(
    parameter int unsigned N_AXIS   = 1,
    parameter int unsigned N_INST   = 1,
    parameter int unsigned THRESH_W = 8,
    parameter int unsigned CNT_W    = 32,
    parameter bit          STICKY   = 1'b0,
    parameter int unsigned ID_W     = (N_AXIS > 1) ? $clog2(N_AXIS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_AXIS-1:0]   axis_block_sigs,
    input  logic [N_INST-1:0]   inst_idle_sigs,
    input  logic [N_INST-1:0]   inst_block_sigs,
    input  logic [THRESH_W-1:0] threshold,
    input  logic                clear,
    output logic                block,
    output logic [1:0]          block_src,
    output logic                first_valid,
    output logic [ID_W-1:0]     first_id,
    output logic [CNT_W-1:0]    stall_cycles
);

    localparam logic [THRESH_W-1:0] PCNT_MAX  = {THRESH_W{1'b1}};
    localparam logic [CNT_W-1:0]    STALL_MAX = {CNT_W{1'b1}};

    logic [THRESH_W-1:0] pcnt_q, pcnt_d;
    logic                block_q, block_d;
    logic [1:0]          block_src_q, block_src_d;
    logic                first_valid_q, first_valid_d;
    logic [ID_W-1:0]     first_id_q, first_id_d;
    logic [CNT_W-1:0]    stall_q, stall_d;

    logic                axis_cand, inst_cand, cand, alarm_set;
    logic [THRESH_W-1:0] thr_eff;
    logic [ID_W-1:0]     low_id;

    // Lowest-index blocked AXIS channel, 0 when none is blocked.
    always_comb begin
        low_id = '0;
        for (int i = int'(N_AXIS) - 1; i >= 0; i--) begin
            if (axis_block_sigs[i]) begin
                low_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        axis_cand = |axis_block_sigs;
        inst_cand = (&(inst_idle_sigs | inst_block_sigs)) & (|inst_block_sigs);
        cand      = axis_cand | inst_cand;
        thr_eff   = (threshold == '0) ? THRESH_W'(1) : threshold;

        pcnt_d        = '0;
        block_d       = 1'b0;
        block_src_d   = '0;
        first_valid_d = first_valid_q;
        first_id_d    = first_id_q;
        stall_d       = stall_q;
        alarm_set     = 1'b0;

        if (clear) begin
            first_valid_d = 1'b0;
            first_id_d    = '0;
            stall_d       = '0;
        end else begin
            if (cand) begin
                pcnt_d = (pcnt_q == PCNT_MAX) ? pcnt_q : pcnt_q + THRESH_W'(1);
            end
            alarm_set = cand & (pcnt_d >= thr_eff);
            block_d   = STICKY ? (block_q | alarm_set) : alarm_set;

            // Sticky alarm keeps the last cause while the condition is gone.
            if (block_d) begin
                block_src_d = cand ? {inst_cand, axis_cand} : block_src_q;
            end

            if (block_d && !block_q && !first_valid_q) begin
                first_valid_d = 1'b1;
                first_id_d    = low_id;
            end

            if (block_q && (stall_q != STALL_MAX)) begin
                stall_d = stall_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pcnt_q        <= '0;
            block_q       <= 1'b0;
            block_src_q   <= '0;
            first_valid_q <= 1'b0;
            first_id_q    <= '0;
            stall_q       <= '0;
        end else begin
            pcnt_q        <= pcnt_d;
            block_q       <= block_d;
            block_src_q   <= block_src_d;
            first_valid_q <= first_valid_d;
            first_id_q    <= first_id_d;
            stall_q       <= stall_d;
        end
    end

    assign block        = block_q;
    assign block_src    = block_src_q;
    assign first_valid  = first_valid_q;
    assign first_id     = first_id_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hls_deadlock_multi_monitor.sv
// Randomized bench: a non-sticky and a sticky monitor share stimulus and are
// compared every cycle against a run-length based behavioural model.
module tb_hls_deadlock_multi_monitor;

    logic       clock = 1'b0;
    logic       reset, clear;
    logic [3:0] axis_block_sigs;
    logic [2:0] inst_idle_sigs, inst_block_sigs;
    logic [7:0] thr_a;
    logic [1:0] thr_b;

    logic       o_block[2];
    logic [1:0] o_src[2];
    logic       o_fv[2];
    logic [1:0] o_fid[2];
    logic [3:0] o_stall[2];

    int checks = 0;
    int errors = 0;

    // model state per instance: 0 = non-sticky/8-bit thr, 1 = sticky/2-bit thr
    int m_run[2], m_src[2], m_fid[2], m_stall[2];
    bit m_blk[2], m_fv[2];

    always #5 clock = ~clock;

    hls_deadlock_multi_monitor #(.N_AXIS(4), .N_INST(3), .THRESH_W(8), .CNT_W(4), .STICKY(1'b0)) dut_a (
        .clock(clock), .reset(reset), .axis_block_sigs(axis_block_sigs),
        .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs),
        .threshold(thr_a), .clear(clear), .block(o_block[0]), .block_src(o_src[0]),
        .first_valid(o_fv[0]), .first_id(o_fid[0]), .stall_cycles(o_stall[0]));

    hls_deadlock_multi_monitor #(.N_AXIS(4), .N_INST(3), .THRESH_W(2), .CNT_W(4), .STICKY(1'b1)) dut_b (
        .clock(clock), .reset(reset), .axis_block_sigs(axis_block_sigs),
        .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs),
        .threshold(thr_b), .clear(clear), .block(o_block[1]), .block_src(o_src[1]),
        .first_valid(o_fv[1]), .first_id(o_fid[1]), .stall_cycles(o_stall[1]));

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step(input int thr);
        int  ac, ic, pc, te, tmax;
        bit  cand, set, nb;
        bit  all_ok, any_blk;
        all_ok  = 1'b1;
        any_blk = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (!(inst_idle_sigs[i] || inst_block_sigs[i])) all_ok = 1'b0;
            if (inst_block_sigs[i]) any_blk = 1'b1;
        end
        ac   = (axis_block_sigs != 0) ? 1 : 0;
        ic   = (all_ok && any_blk) ? 1 : 0;
        cand = (ac + ic) != 0;
        for (int d = 0; d < 2; d++) begin
            if (reset || clear) begin
                m_run[d] = 0; m_blk[d] = 0; m_src[d] = 0;
                m_fv[d] = 0; m_fid[d] = 0; m_stall[d] = 0;
            end else begin
                tmax = (d == 0) ? 255 : 3;
                m_run[d] = cand ? ((m_run[d] < 1000) ? m_run[d] + 1 : m_run[d]) : 0;
                pc  = (m_run[d] > tmax) ? tmax : m_run[d];
                te  = thr & tmax;
                if (te == 0) te = 1;
                set = cand && (pc >= te);
                nb  = (d == 1) ? (m_blk[d] || set) : set;
                if (m_blk[d] && m_stall[d] < 15) m_stall[d]++;
                if (nb && !m_blk[d] && !m_fv[d]) begin
                    m_fv[d]  = 1;
                    m_fid[d] = 0;
                    for (int i = 3; i >= 0; i--) if (axis_block_sigs[i]) m_fid[d] = i;
                end
                if (!nb) m_src[d] = 0;
                else if (cand) m_src[d] = ic * 2 + ac;
                m_blk[d] = nb;
            end
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            string s;
            s = (d == 0) ? "a" : "b";
            check({s, ".block"}, int'(o_block[d]), int'(m_blk[d]));
            check({s, ".block_src"}, int'(o_src[d]), m_src[d]);
            check({s, ".first_valid"}, int'(o_fv[d]), int'(m_fv[d]));
            check({s, ".first_id"}, int'(o_fid[d]), m_fid[d]);
            check({s, ".stall"}, int'(o_stall[d]), m_stall[d]);
        end
    endtask

    task automatic cycle(input logic [3:0] ax, input logic [2:0] idl, input logic [2:0] blk,
                         input int thr, input bit clr, input bit rst);
        axis_block_sigs = ax;
        inst_idle_sigs  = idl;
        inst_block_sigs = blk;
        thr_a  = 8'(thr);
        thr_b  = 2'(thr);
        clear  = clr;
        reset  = rst;
        model_step(thr);
        @(negedge clock);
        compare_all();
    endtask

    initial begin
        logic [3:0] ax;
        logic [2:0] idl, blk;
        int thr;
        for (int d = 0; d < 2; d++) begin
            m_run[d] = 0; m_blk[d] = 0; m_src[d] = 0;
            m_fv[d] = 0; m_fid[d] = 0; m_stall[d] = 0;
        end
        cycle(4'b0000, 3'b111, 3'b000, 1, 1'b0, 1'b1);
        cycle(4'b0000, 3'b111, 3'b000, 1, 1'b0, 1'b1);
        check("reset.block", int'(o_block[0]), 0);
        check("reset.stall", int'(o_stall[1]), 0);

        // Baseline single-cycle pulse on channel 2
        cycle(4'b0100, 3'b111, 3'b000, 1, 1'b0, 1'b0);
        check("base.block", int'(o_block[0]), 1);
        check("base.first_id", int'(o_fid[0]), 2);
        check("base.src", int'(o_src[0]), 1);
        cycle(4'b0000, 3'b111, 3'b000, 1, 1'b0, 1'b0);
        check("base.fall", int'(o_block[0]), 0);
        check("base.stall", int'(o_stall[0]), 1);
        check("sticky.hold", int'(o_block[1]), 1);
        for (int i = 0; i < 20; i++) cycle(4'b0000, 3'b111, 3'b000, 1, 1'b0, 1'b0);
        check("sticky.sat", int'(o_stall[1]), 15);
        cycle(4'b0000, 3'b111, 3'b000, 1, 1'b1, 1'b0);
        check("clear.block", int'(o_block[1]), 0);
        check("clear.fv", int'(o_fv[1]), 0);

        // Persistence: 4 cycles below threshold 5, then 5 cycles
        for (int i = 0; i < 4; i++) cycle(4'b1000, 3'b111, 3'b000, 5, 1'b0, 1'b0);
        check("pers.short", int'(o_block[0]), 0);
        cycle(4'b0000, 3'b111, 3'b000, 5, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(4'b1000, 3'b111, 3'b000, 5, 1'b0, 1'b0);
        check("pers.rise", int'(o_block[0]), 1);
        check("pers.src", int'(o_src[0]), 1);
        cycle(4'b0000, 3'b111, 3'b000, 1, 1'b1, 1'b0);

        // Instance deadlock then instance 2 goes busy
        cycle(4'b0000, 3'b101, 3'b010, 2, 1'b0, 1'b0);
        check("inst.wait", int'(o_block[0]), 0);
        cycle(4'b0000, 3'b101, 3'b010, 2, 1'b0, 1'b0);
        check("inst.rise", int'(o_block[0]), 1);
        check("inst.src", int'(o_src[0]), 2);
        check("inst.fid", int'(o_fid[0]), 0);
        cycle(4'b0000, 3'b001, 3'b010, 2, 1'b0, 1'b0);
        check("inst.fall", int'(o_block[0]), 0);
        cycle(4'b0000, 3'b111, 3'b000, 1, 1'b1, 1'b0);

        // Clear on the rising cycle wins: no capture
        cycle(4'b0010, 3'b111, 3'b000, 1, 1'b1, 1'b0);
        check("clrcol.fv", int'(o_fv[0]), 0);
        // Reset mid-alarm
        cycle(4'b0010, 3'b111, 3'b000, 0, 1'b0, 1'b0);
        cycle(4'b0010, 3'b111, 3'b000, 0, 1'b0, 1'b0);
        cycle(4'b0010, 3'b111, 3'b000, 0, 1'b0, 1'b1);
        check("rstmid.block", int'(o_block[0]), 0);
        check("rstmid.stall", int'(o_stall[1]), 0);

        // Randomized phase with held patterns so persistence builds up
        ax = 4'b0000; idl = 3'b111; blk = 3'b000; thr = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) ax = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                idl = 3'($urandom);
                blk = 3'($urandom);
            end
            if ($urandom_range(0, 30) == 0) thr = int'($urandom_range(0, 6));
            cycle(ax, idl, blk, thr, $urandom_range(0, 40) == 0, $urandom_range(0, 150) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hls_deadlock_multi_monitor.md
# hls_deadlock_multi_monitor

Parametrised deadlock/stall monitor for HLS dataflow regions with multiple AXI-Stream channels and multiple sub-instances. It adds a persistence threshold, an optional sticky alarm, first-blocker capture and a saturating stall-cycle counter. It sits beside a dataflow region and feeds the design-level deadlock report and debug registers. In the minimal configuration (N_AXIS=1, N_INST=1, STICKY=0, threshold=1) it reproduces the single-channel monitor behaviour: alarm one cycle after an AXIS block.

## Interface
- N_AXIS, 1: number of monitored AXI-Stream block signals.
- N_INST, 1: number of monitored sub-instances.
- THRESH_W, 8: width of the threshold and persistence counter.
- CNT_W, 32: width of the stall-cycle counter.
- STICKY, 0: 1 = alarm holds until `clear`; 0 = alarm follows the condition.
- ID_W, max(1, clog2(N_AXIS)): width of the channel index.

Ports:
- clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- axis_block_sigs  in  N_AXIS  per-channel AXIS blocked indication.
- inst_idle_sigs  in  N_INST  per-instance idle.
- inst_block_sigs  in  N_INST  per-instance blocked.
- threshold  in  THRESH_W  consecutive candidate cycles required before alarm; 0 is treated as 1.
- clear  in  1  one-cycle pulse; clears alarm, capture and counters.
- block  out  1  registered deadlock alarm.
- block_src  out  2  registered: bit0 = AXIS cause, bit1 = instance cause.
- first_valid  out  1  a first-blocker capture is held.
- first_id  out  ID_W  lowest-index AXIS channel blocked when the alarm first rose.
- stall_cycles  out  CNT_W  saturating count of cycles with `block`=1.

## Operation
- axis_cand = OR(axis_block_sigs).
- inst_cand = (&(inst_idle_sigs | inst_block_sigs)) & (|inst_block_sigs): every instance is idle or blocked, and at least one is blocked.
- cand = axis_cand | inst_cand.
- thr_eff = (threshold==0) ? 1 : threshold.
- Persistence counter `pcnt` (THRESH_W bits):
  - cand=1: pcnt_n = sat(pcnt+1), saturating at all-ones.
  - cand=0: pcnt_n = 0.
- Alarm update:
  - STICKY=0: block <= cand & (pcnt_n >= thr_eff).
  - STICKY=1: block <= block | (cand & (pcnt_n >= thr_eff)).
- block_src is loaded with {inst_cand, axis_cand} on every cycle whose next `block` is 1. It is zeroed when the next `block` is 0. In STICKY mode it holds its last nonzero value while `block` stays set and cand drops.
- First-blocker capture:
  - On the 0→1 transition of `block` when first_valid=0: first_valid <= 1.
  - first_id <= lowest set index of axis_block_sigs in that cycle, or 0 if none is set (instance cause only).
  - No further captures until `clear`.
- stall_cycles increments on every cycle where registered `block`=1, and saturates at 2^CNT_W−1.
- Priority: reset > clear > normal update.
  - clear=1: pcnt, block, block_src, first_valid, first_id and stall_cycles go to 0 at the next edge. Inputs in that cycle are ignored.
- Changing threshold mid-run takes effect immediately, compared against the current pcnt_n.

## Timing
- Reset values: all outputs 0, pcnt 0.
- Alarm latency: cand held from cycle k raises `block` after the edge of cycle k+thr_eff−1. Threshold 1 gives block=1 one cycle after cand.
- STICKY=0: block falls one cycle after cand drops. A single-cycle cand gap restarts the count from 0.
- Saturated pcnt keeps the alarm asserted for any thr_eff ≤ 2^THRESH_W−1.
- stall_cycles lags `block` by one cycle. It reads 1 after the first cycle of `block`=1.
- clear asserted in the same cycle as the 0→1 alarm edge: clear wins, no capture.
- Reset mid-alarm: all state returns to 0 at the next edge.

## Test plan
- Baseline: N_AXIS=4, threshold=1, pulse axis_block_sigs=4'b0100 for 1 cycle. Expect block=1 for exactly one cycle, one cycle later; first_id=2; first_valid=1; stall_cycles=1.
- Persistence: threshold=5, cand held 4 cycles then dropped. Expect block never set. Then hold cand 5 cycles: block rises after the 5th edge; block_src=2'b01.
- Instance deadlock: N_INST=3, idle=3'b101, block=3'b010, no AXIS block, threshold=2. Expect block after 2 cycles; block_src=2'b10; first_id=0. Then set idle=3'b001 with block=3'b010 (instance 2 busy): block falls next cycle (STICKY=0).
- Sticky: STICKY=1, threshold=1, 3-cycle cand burst then idle. Expect block held and stall_cycles growing every cycle. clear pulse: all outputs 0 next cycle.
- Saturation: CNT_W=4, hold alarm 20 cycles. Expect stall_cycles=15 and held. THRESH_W=2 with threshold=0 behaves as 1.
- Reset/clear collisions: assert clear on the cycle the alarm would rise, expect no capture. Assert reset mid-alarm, expect all outputs 0 on the next edge.
